// File: rtl/bitcoin_nonce_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module      : bitcoin_nonce_sweeper_if
// Description : Single-port synchronous word-memory bus shared by the hash
//               engines. The master drives clock, write enable, address and
//               write data. The slave returns read data one cycle after the
//               address.
//   mem_clk        master -> slave  memory clock
//   mem_we         master -> slave  write enable
//   mem_addr       master -> slave  16-bit word address
//   mem_write_data master -> slave  32-bit write data
//   mem_read_data  slave  -> master 32-bit read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
interface bitcoin_nonce_sweeper_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (output mem_clk, mem_we, mem_addr, mem_write_data,
                    input  mem_read_data);
    modport slave  (input  mem_clk, mem_we, mem_addr, mem_write_data,
                    output mem_read_data);
endinterface
`default_nettype wire

// File: rtl/bitcoin_nonce_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : bitcoin_nonce_sweeper
// Description : Bitcoin-style nonce search. It reads a 19-word header and
//               computes the first-block midstate once. Then, for each of
//               NUM_NONCES nonces, it computes the double SHA-256, writes the
//               final H0 to memory and records the first nonce whose H0 is
//               below the target. One iterative round datapath is shared by
//               all three compressions.
//   clk, reset_n      clock, asynchronous active-low reset
//   start             begin a sweep (sampled in IDLE only)
//   message_addr      word address of header word 0
//   output_addr       word address of nonce 0's H0
//   target            compare threshold (latched at start)
//   done              one-cycle completion pulse
//   found/found_nonce first qualifying nonce (valid from done)
//   mem               memory bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module bitcoin_nonce_sweeper #(
    parameter int unsigned NUM_NONCES  = 16,
    parameter logic [31:0] NONCE_START = 32'd0
) (
    input  wire                     clk,
    input  wire                     reset_n,
    input  wire                     start,
    input  wire [15:0]              message_addr,
    input  wire [15:0]              output_addr,
    input  wire [31:0]              target,
    output logic                    done,
    output logic                    found,
    output logic [31:0]             found_nonce,
    bitcoin_nonce_sweeper_if.master mem
);
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_COMP1, S_COMP2, S_COMP3, S_WRITE, S_DONE
    } state_t;

    localparam logic [31:0] c_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] c_iv [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [6:0] c_read_last = 7'd19;   // 19 addresses + 1 trailing capture
    localparam logic [6:0] c_comp_last = 7'd65;   // load + 64 rounds + final add
    localparam logic [7:0] c_last_idx  = 8'(NUM_NONCES - 1);

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] msg_addr_q, msg_addr_d, out_addr_q, out_addr_d;
    logic [31:0] target_q, target_d;
    logic [31:0] hdr_q [19], hdr_d [19];
    logic [31:0] mid_q [8],  mid_d [8];    // first-block midstate
    logic [31:0] hv_q  [8],  hv_d  [8];    // chaining value of current compression
    logic [31:0] wk_q  [8],  wk_d  [8];    // working variables a..h
    logic [31:0] w_q   [16], w_d   [16];   // rolling message schedule window
    logic        done_q, done_d, found_q, found_d;
    logic [31:0] found_nonce_q, found_nonce_d;

    logic [31:0] w_nonce, w_t1, w_t2, w_sched;
    logic [31:0] w_blk [16];
    logic [31:0] w_init [8];

    assign w_nonce = NONCE_START + {24'd0, idx_q};

    // One SHA-256 round on a..h and the next schedule word. W[t] is always
    // at the head of the window, so W[t+16] is built from fixed taps.
    always_comb begin
        w_t1 = wk_q[7]
             + (rotr(wk_q[4], 6) ^ rotr(wk_q[4], 11) ^ rotr(wk_q[4], 25))
             + ((wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]))
             + c_k[6'(cnt_q - 7'd1)] + w_q[0];
        w_t2 = (rotr(wk_q[0], 2) ^ rotr(wk_q[0], 13) ^ rotr(wk_q[0], 22))
             + ((wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]));
        w_sched = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
                + w_q[9]
                + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
                + w_q[0];
    end

    // Message block and initial chaining value for each compression.
    always_comb begin
        for (int j = 0; j < 16; j++) w_blk[j] = 32'd0;
        for (int j = 0; j < 8; j++)  w_init[j] = c_iv[j];
        case (state_q)
            S_COMP1: for (int j = 0; j < 16; j++) w_blk[j] = hdr_q[j];
            S_COMP2: begin
                w_blk[0]  = hdr_q[16];
                w_blk[1]  = hdr_q[17];
                w_blk[2]  = hdr_q[18];
                w_blk[3]  = w_nonce;
                w_blk[4]  = 32'h80000000;
                w_blk[15] = 32'd640;          // 80-byte message length
                for (int j = 0; j < 8; j++) w_init[j] = mid_q[j];
            end
            S_COMP3: begin
                for (int j = 0; j < 8; j++) w_blk[j] = hv_q[j];
                w_blk[8]  = 32'h80000000;
                w_blk[15] = 32'd256;          // 32-byte digest length
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        msg_addr_d    = msg_addr_q;
        out_addr_d    = out_addr_q;
        target_d      = target_q;
        hdr_d         = hdr_q;
        mid_d         = mid_q;
        hv_d          = hv_q;
        wk_d          = wk_q;
        w_d           = w_q;
        done_d        = 1'b0;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        case (state_q)
            S_IDLE: if (start) begin
                msg_addr_d    = message_addr;
                out_addr_d    = output_addr;
                target_d      = target;
                found_d       = 1'b0;
                found_nonce_d = 32'd0;
                idx_d         = 8'd0;
                cnt_d         = 7'd0;
                state_d       = S_READ;
            end
            S_READ: begin
                // Data for the address issued last cycle arrives now.
                if (cnt_q != 7'd0) hdr_d[5'(cnt_q - 7'd1)] = mem.mem_read_data;
                if (cnt_q == c_read_last) begin
                    cnt_d   = 7'd0;
                    state_d = S_COMP1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_COMP1, S_COMP2, S_COMP3: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'd0) begin
                    wk_d = w_init;
                    hv_d = w_init;
                    w_d  = w_blk;
                end else if (cnt_q == c_comp_last) begin
                    for (int j = 0; j < 8; j++) hv_d[j] = hv_q[j] + wk_q[j];
                    if (state_q == S_COMP1)
                        for (int j = 0; j < 8; j++) mid_d[j] = hv_q[j] + wk_q[j];
                    cnt_d = 7'd0;
                    case (state_q)
                        S_COMP1: state_d = S_COMP2;
                        S_COMP2: state_d = S_COMP3;
                        default: state_d = S_WRITE;
                    endcase
                end else begin
                    wk_d[7] = wk_q[6];
                    wk_d[6] = wk_q[5];
                    wk_d[5] = wk_q[4];
                    wk_d[4] = wk_q[3] + w_t1;
                    wk_d[3] = wk_q[2];
                    wk_d[2] = wk_q[1];
                    wk_d[1] = wk_q[0];
                    wk_d[0] = w_t1 + w_t2;
                    for (int j = 0; j < 15; j++) w_d[j] = w_q[j + 1];
                    w_d[15] = w_sched;
                end
            end
            S_WRITE: begin
                if (!found_q && (hv_q[0] < target_q)) begin
                    found_d       = 1'b1;
                    found_nonce_d = w_nonce;
                end
                cnt_d = 7'd0;
                if (idx_q == c_last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_COMP2;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 7'd0;
            idx_q         <= 8'd0;
            msg_addr_q    <= 16'd0;
            out_addr_q    <= 16'd0;
            target_q      <= 32'd0;
            hdr_q         <= '{default: 32'd0};
            mid_q         <= '{default: 32'd0};
            hv_q          <= '{default: 32'd0};
            wk_q          <= '{default: 32'd0};
            w_q           <= '{default: 32'd0};
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            msg_addr_q    <= msg_addr_d;
            out_addr_q    <= out_addr_d;
            target_q      <= target_d;
            hdr_q         <= hdr_d;
            mid_q         <= mid_d;
            hv_q          <= hv_d;
            wk_q          <= wk_d;
            w_q           <= w_d;
            done_q        <= done_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
        end
    end

    assign done        = done_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;

    assign mem.mem_clk        = clk;
    assign mem.mem_we         = (state_q == S_WRITE);
    assign mem.mem_addr       = (state_q == S_READ && cnt_q < c_read_last) ? msg_addr_q + {9'd0, cnt_q} :
                                (state_q == S_WRITE)                        ? out_addr_q + {8'd0, idx_q} :
                                                                              16'd0;
    assign mem.mem_write_data = (state_q == S_WRITE) ? hv_q[0] : 32'd0;
endmodule
`default_nettype wire
